// File: rtl/alu_exec.sv
// alu_exec: execute stage fed by the register file read ports.
// Single-cycle ADD/SUB/AND/OR/XOR/SLL/SRL may issue every cycle. MUL is an
// iterative shift-add multiplier that holds busy for DATA_W cycles.
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   start, op         issue request and opcode (accepted when !busy)
//   RD1, RD2, WA_in   operands and destination register
//   ALUResult, WA     registered result and destination
//   write_enable      one-cycle write-back strobe
//   busy              high while a MUL is in progress
//   zero, carry       flags, updated only together with write_enable
module alu_exec #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] WA_in,
  output logic [DATA_W-1:0] ALUResult,
  output logic [ADDR_W-1:0] WA,
  output logic              write_enable,
  output logic              busy,
  output logic              zero,
  output logic              carry
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSll = 3'b101;
  localparam logic [2:0] OpSrl = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     res_q, res_d;
  logic [ADDR_W-1:0]     wa_q, wa_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]     dest_q, dest_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [DATA_W-1:0]     alu_res;
  logic                  alu_c;
  logic [DATA_W:0]       sum_w, diff_w, sll_w, srl_w;
  logic [2:0]            sh;
  logic [2*DATA_W-1:0]   acc_step;

  // Single-cycle datapath. Shifts are done one bit wider so the last bit
  // shifted out lands in the extra bit; a zero shift leaves it clear.
  always_comb begin
    sh     = RD2[2:0];
    sum_w  = {1'b0, RD1} + {1'b0, RD2};
    diff_w = {1'b0, RD1} - {1'b0, RD2};
    sll_w  = {1'b0, RD1} << sh;
    srl_w  = {RD1, 1'b0} >> sh;
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (op)
      OpAdd: begin alu_res = sum_w[DATA_W-1:0];  alu_c = sum_w[DATA_W];  end
      OpSub: begin alu_res = diff_w[DATA_W-1:0]; alu_c = diff_w[DATA_W]; end
      OpAnd: alu_res = RD1 & RD2;
      OpOr:  alu_res = RD1 | RD2;
      OpXor: alu_res = RD1 ^ RD2;
      OpSll: begin alu_res = sll_w[DATA_W-1:0]; alu_c = sll_w[DATA_W]; end
      OpSrl: begin alu_res = srl_w[DATA_W:1];   alu_c = srl_w[0];      end
      OpMul: begin alu_res = '0; alu_c = 1'b0; end
      default: begin alu_res = '0; alu_c = 1'b0; end
    endcase
  end

  // One shift-add step: the multiplier is consumed LSB first while the
  // multiplicand walks left, so it is always aligned to the current bit.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    wa_d     = wa_q;
    we_d     = 1'b0;
    busy_d   = busy_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    dest_d   = dest_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op == OpMul) begin
            mcand_d  = {{DATA_W{1'b0}}, RD1};
            mplier_d = RD2;
            dest_d   = WA_in;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = StMul;
          end else begin
            res_d   = alu_res;
            carry_d = alu_c;
            zero_d  = (alu_res == '0);
            wa_d    = WA_in;
            we_d    = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) begin
          res_d   = acc_step[DATA_W-1:0];
          carry_d = |acc_step[2*DATA_W-1:DATA_W];
          zero_d  = (acc_step[DATA_W-1:0] == '0);
          wa_d    = dest_q;
          we_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      res_q    <= '0;
      wa_q     <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      dest_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      wa_q     <= wa_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      dest_q   <= dest_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ALUResult    = res_q;
  assign WA           = wa_q;
  assign write_enable = we_q;
  assign busy         = busy_q;
  assign zero         = zero_q;
  assign carry        = carry_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          CLK;
  logic          RST_N;
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] RD1, RD2;
  logic [AW-1:0] WA_in;
  logic [DW-1:0] ALUResult;
  logic [AW-1:0] WA;
  logic          write_enable, busy, zero, carry;

  alu_exec #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .op(op), .RD1(RD1), .RD2(RD2),
    .WA_in(WA_in), .ALUResult(ALUResult), .WA(WA), .write_enable(write_enable),
    .busy(busy), .zero(zero), .carry(carry)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge counter plus the edge number at which an
  // outstanding multiply delivers its product.
  int edge_n    = 0;
  int mul_due   = -1;
  int mul_prod  = 0;
  int mul_dest  = 0;
  int e_res = 0, e_wa = 0, e_we = 0, e_zero = 0, e_carry = 0;

  function automatic void ref_alu(input int o, input int a, input int b,
                                  output int r, output int c);
    int s, n;
    n = b % 8;
    c = 0;
    case (o)
      0: begin s = a + b; r = s % 256; c = (s >= 256) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin s = a * (1 << n); r = s % 256; c = (s / 256) % 2; end
      6: begin r = a / (1 << n); c = (n == 0) ? 0 : (a / (1 << (n - 1))) % 2; end
      default: r = 0;
    endcase
  endfunction

  task automatic deliver(input int r, input int c, input int w);
    e_res = r; e_carry = c; e_zero = (r == 0) ? 1 : 0; e_wa = w; e_we = 1;
  endtask

  task automatic model_edge(input int rst_n, input int st, input int o,
                            input int a, input int b, input int w);
    int r, c;
    edge_n++;
    e_we = 0;
    if (rst_n == 0) begin
      e_res = 0; e_wa = 0; e_zero = 0; e_carry = 0; mul_due = -1;
    end else if (mul_due == edge_n) begin
      deliver(mul_prod % 256, (mul_prod >= 256) ? 1 : 0, mul_dest);
      mul_due = -1;
    end else if (mul_due < 0 && st != 0) begin
      if (o == 7) begin
        mul_prod = a * b; mul_dest = w; mul_due = edge_n + DW;
      end else begin
        ref_alu(o, a, b, r, c);
        deliver(r, c, w);
      end
    end
  endtask

  task automatic step(input int rst_n, input int st, input int o,
                      input int a, input int b, input int w);
    @(negedge CLK);
    RST_N = rst_n[0]; start = st[0]; op = o[2:0];
    RD1 = a[DW-1:0]; RD2 = b[DW-1:0]; WA_in = w[AW-1:0];
    @(posedge CLK);
    model_edge(rst_n, st, o, a, b, w);
    #1;
    check_eq("we",    int'(write_enable), e_we);
    check_eq("busy",  int'(busy), (mul_due >= 0) ? 1 : 0);
    check_eq("res",   int'(ALUResult), e_res);
    check_eq("wa",    int'(WA), e_wa);
    check_eq("zero",  int'(zero), e_zero);
    check_eq("carry", int'(carry), e_carry);
  endtask

  int busy_cnt;

  initial begin
    RST_N = 1'b0; start = 1'b0; op = '0; RD1 = '0; RD2 = '0; WA_in = '0;

    // Reset beats start; first released edge accepts ADD 200+100.
    step(0, 1, 0, 9, 0, 0);
    step(0, 1, 0, 9, 0, 0);
    check_eq("rst_res", int'(ALUResult), 0);
    check_eq("rst_we", int'(write_enable), 0);
    step(1, 1, 0, 200, 100, 3);
    check_eq("add_res", int'(ALUResult), 44);
    check_eq("add_carry", int'(carry), 1);
    step(1, 0, 0, 0, 0, 0);
    check_eq("add_we_once", int'(write_enable), 0);

    // Back-to-back SUBs.
    step(1, 1, 1, 5, 5, 1);
    check_eq("sub0_zero", int'(zero), 1);
    step(1, 1, 1, 3, 5, 2);
    check_eq("sub1_res", int'(ALUResult), 254);
    check_eq("sub1_we", int'(write_enable), 1);

    // Shift and XOR boundaries.
    step(1, 1, 5, 8'h81, 1, 4);
    check_eq("sll_res", int'(ALUResult), 2);
    check_eq("sll_carry", int'(carry), 1);
    step(1, 1, 6, 8'h81, 0, 4);
    check_eq("srl0_res", int'(ALUResult), 8'h81);
    step(1, 1, 4, 8'hAA, 8'hAA, 4);
    check_eq("xor_zero", int'(zero), 1);

    // MUL 13*11 with ADD requests while busy.
    step(1, 1, 7, 13, 11, 5);
    busy_cnt = 1;
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 1, 1, 9);
      if (busy) busy_cnt++;
    end
    step(1, 0, 0, 0, 0, 0);
    check_eq("mul_busy_len", busy_cnt, 8);
    check_eq("mul_res", int'(ALUResult), 143);
    check_eq("mul_wa", int'(WA), 5);
    step(1, 1, 7, 20, 15, 6);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
    check_eq("mul2_res", int'(ALUResult), 44);
    check_eq("mul2_carry", int'(carry), 1);

    // Reset aborts a MUL at the 4th iteration edge.
    step(1, 1, 7, 13, 11, 5);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("abort_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 7);
    check_eq("post_abort_add", int'(ALUResult), 2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0) ? 1 : 0, ($urandom_range(0, 2) != 0) ? 1 : 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage directly downstream of the register file.
- Consumes the RD1/RD2 operands and the destination address, and produces ALUResult, the write-back address and the write_enable strobe that feed the register file's write port.
- Logic and shift ops complete in one cycle and may issue every cycle.
- MUL is an iterative shift-add multiplier that holds busy for DATA_W cycles.

Parameters:
DATA_W, 8, operand/result width; MUL iteration count equals DATA_W
ADDR_W, 4, register address width

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_N  in  1  reset, synchronous, active-low
start  in  1  issue request; accepted on an edge where start=1, busy=0, RST_N=1
op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL
RD1  in  DATA_W  operand A (register file read port 1)
RD2  in  DATA_W  operand B (register file read port 2); shifts use RD2[2:0] as amount
WA_in  in  ADDR_W  destination register for this op
ALUResult  out  DATA_W  registered result
WA  out  ADDR_W  registered destination, valid with write_enable
write_enable  out  1  one-cycle write-back strobe
busy  out  1  high while a MUL is in progress
zero  out  1  ALUResult==0, updated only with write_enable
carry  out  1  op-dependent carry flag, updated only with write_enable

Behaviour:
- Reset (RST_N=0 at an edge): state IDLE; ALUResult=0, WA=0, write_enable=0, busy=0, zero=0, carry=0. Reset beats start. Reset mid-MUL aborts the op: no write_enable, busy=0 after that edge.
- States: IDLE, MUL.
- IDLE, accepted single-cycle op at edge k:
  - At edge k, register ALUResult, WA<=WA_in, zero, carry; write_enable=1 for exactly the cycle after edge k.
  - Stay in IDLE, so start on consecutive edges yields consecutive pulses.
- IDLE, accepted MUL at edge k:
  - Latch multiplicand=RD1, multiplier=RD2, dest=WA_in; acc=0 (2*DATA_W bits), count=0; busy=1; go to MUL.
- MUL:
  - On each edge, one step: if multiplier LSB=1, acc+=multiplicand shifted left by count; count+=1.
  - At the edge performing step DATA_W (edge k+8 for DATA_W=8): ALUResult=acc[DATA_W-1:0] of the final sum; carry=|acc[2*DATA_W-1:DATA_W]; zero from the low half; WA=dest; write_enable=1 for one cycle; busy=0; return to IDLE.
  - start while busy is ignored. A new start may be accepted on the edge after busy falls.
- Arithmetic, modulo 2^DATA_W:
  - ADD: carry = bit DATA_W of RD1+RD2.
  - SUB: RD1-RD2; carry=1 iff RD1<RD2 (borrow).
  - AND/OR/XOR: carry=0.
  - SLL/SRL by n=RD2[2:0]: zero-fill; carry = last bit shifted out (RD1[DATA_W-n] for SLL, RD1[n-1] for SRL); n=0 gives carry=0 and result=RD1.
- Hold: when write_enable=0, ALUResult, WA, zero and carry keep their last values.
- Inputs are sampled only at the accepting edge. Changes to RD1/RD2/WA_in/op during MUL have no effect.

Test Plan:
1. RST_N=0 for 2 edges with start=1, op=ADD, RD1=9 -> all outputs 0, no write_enable; the first edge with RST_N=1 accepts the op.
2. ADD RD1=200, RD2=100, WA_in=3 -> next cycle ALUResult=44, carry=1, zero=0, WA=3, write_enable=1 for one cycle only.
3. Back-to-back issue: SUB 5-5 (WA_in=1), then SUB 3-5 (WA_in=2) on consecutive edges -> pulse 1: ALUResult=0, zero=1, carry=0, WA=1; pulse 2: ALUResult=254, zero=0, carry=1, WA=2; write_enable high 2 consecutive cycles.
4. SLL RD1=0x81 by 1 -> 0x02, carry=1. SRL 0x81 by 0 -> 0x81, carry=0. XOR 0xAA^0xAA -> 0x00, zero=1, carry=0.
5. MUL 13*11, WA_in=5 -> busy=1 for 8 cycles; at edge k+8 ALUResult=143, carry=0, WA=5, single pulse. A start (ADD) asserted during busy produces no pulse. MUL 20*15 -> ALUResult=44, carry=1.
6. MUL 13*11 accepted, RST_N=0 at the 4th iteration edge -> no write_enable ever for it, busy=0 after that edge. Then ADD 1+1 -> ALUResult=2 normally.
